// File: rtl/rr_select_ctrl.sv
// rr_select_ctrl: round-robin arbiter that drives the selector of an N:1 data mux.
// It holds the selector for a whole transaction and hands it downstream with a
// valid/ready handshake. The winner gets a one-cycle ack when the beat is accepted.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   req        per-requester request, bit i means mux input i holds data
//   out_ready  downstream accepts the current beat
//   out_valid  selector is valid, mux output is a valid beat (registered)
//   selector   mux selector, always < N_INPUTS (registered)
//   grant      one-hot copy of selector, zero when out_valid=0 (registered)
//   ack        grant & accept, one-cycle pulse to the winner (combinational)
module rr_select_ctrl #(
  parameter int unsigned N_INPUTS = 4,
  localparam int unsigned SEL_W = $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] req,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [SEL_W-1:0]    selector,
  output logic [N_INPUTS-1:0] grant,
  output logic [N_INPUTS-1:0] ack
);

  localparam logic [N_INPUTS-1:0] ONE     = N_INPUTS'(1);
  localparam logic [SEL_W-1:0]    SEL_MAX = SEL_W'(N_INPUTS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nx;
  logic [SEL_W-1:0]     ptr, ptr_nx, ptr_acc;
  logic [SEL_W-1:0]     sel_nx;
  logic [N_INPUTS-1:0]  grant_nx;
  logic [SEL_W:0]       arb_idle, arb_b2b;

  // First set bit of v searching from p upward with wrap; returns {found, index}.
  // The doubled vector makes the wrap a plain shift, and the index is brought
  // back into range with an explicit compare so non-power-of-2 N stays legal.
  function automatic logic [SEL_W:0] arbitrate(input logic [N_INPUTS-1:0] v,
                                               input logic [SEL_W-1:0]    p);
    logic [2*N_INPUTS-1:0] rot;
    logic                  found;
    logic [SEL_W-1:0]      idx;
    int unsigned           pos;
    rot   = {v, v} >> p;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos   = 32'(p) + k;
        if (pos >= N_INPUTS) pos = pos - N_INPUTS;
        idx   = SEL_W'(pos);
      end
    end
    return {found, idx};
  endfunction

  // Next-state, pointer and selector/grant load decisions.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = selector;
    grant_nx = grant;
    ptr_acc  = (selector == SEL_MAX) ? '0 : selector + SEL_W'(1);
    arb_idle = arbitrate(req, ptr);
    // The current winner is masked so a lone requester cannot be regranted
    // in the same cycle it is acked.
    arb_b2b  = arbitrate(req & ~grant, ptr_acc);
    unique case (state)
      IDLE: begin
        if (arb_idle[SEL_W]) begin
          state_nx = BUSY;
          sel_nx   = arb_idle[SEL_W-1:0];
          grant_nx = ONE << arb_idle[SEL_W-1:0];
        end
      end
      BUSY: begin
        if (out_ready) begin
          ptr_nx = ptr_acc;
          if (arb_b2b[SEL_W]) begin
            sel_nx   = arb_b2b[SEL_W-1:0];
            grant_nx = ONE << arb_b2b[SEL_W-1:0];
          end else begin
            state_nx = IDLE;
            grant_nx = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any pending transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      selector  <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      selector  <= sel_nx;
      grant     <= grant_nx;
      out_valid <= (state_nx == BUSY);
    end
  end

  assign ack = grant & {N_INPUTS{out_valid & out_ready}};

endmodule

// File: tb/tb_rr_select_ctrl.sv
// Testbench for rr_select_ctrl: directed scenarios plus randomized traffic on a
// 4-input and a 3-input instance, checked against a behavioural arbiter model.
module tb_rr_select_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req4 = '0;
  logic       rdy4 = 1'b0;
  logic       v4;
  logic [1:0] s4;
  logic [3:0] g4, a4;
  logic [2:0] req3 = '0;
  logic       rdy3 = 1'b0;
  logic       v3;
  logic [1:0] s3;
  logic [2:0] g3, a3;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model state: index 0 is the 4-input DUT, index 1 the 3-input DUT.
  bit m_busy [2];
  int m_sel  [2];
  int m_ptr  [2];

  always #5 clk = ~clk;

  rr_select_ctrl #(.N_INPUTS(4)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .out_ready(rdy4),
    .out_valid(v4), .selector(s4), .grant(g4), .ack(a4)
  );

  rr_select_ctrl #(.N_INPUTS(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .out_ready(rdy3),
    .out_valid(v3), .selector(s3), .grant(g3), .ack(a3)
  );

  // Round-robin search: first requester at or after p, wrapping modulo n.
  function automatic int pick(int n, logic [63:0] v, int p);
    for (int k = 0; k < n; k++) begin
      if (v[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_sel[d]  = 0;
      m_ptr[d]  = 0;
    end
  endfunction

  // One clock of the transaction-level behaviour for instance d.
  function automatic void model_update(int d, int n, logic [63:0] v, logic r);
    int w;
    logic [63:0] others;
    if (!m_busy[d]) begin
      w = pick(n, v, m_ptr[d]);
      if (w >= 0) begin
        m_busy[d] = 1'b1;
        m_sel[d]  = w;
      end
    end else if (r) begin
      m_ptr[d] = (m_sel[d] + 1) % n;
      others = v;
      others[m_sel[d]] = 1'b0;
      w = pick(n, others, m_ptr[d]);
      if (w >= 0) m_sel[d] = w;
      else        m_busy[d] = 1'b0;
    end
  endfunction

  // Expected {out_valid, selector, grant, ack} for each instance.
  function automatic logic [10:0] exp4();
    logic [3:0] g;
    g = m_busy[0] ? 4'(1 << m_sel[0]) : 4'b0;
    return {m_busy[0], 2'(m_sel[0]), g, (m_busy[0] && rdy4) ? g : 4'b0};
  endfunction

  function automatic logic [8:0] exp3();
    logic [2:0] g;
    g = m_busy[1] ? 3'(1 << m_sel[1]) : 3'b0;
    return {m_busy[1], 2'(m_sel[1]), g, (m_busy[1] && rdy3) ? g : 3'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update(0, 4, {60'b0, req4}, rdy4);
    model_update(1, 3, {61'b0, req3}, rdy3);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req4 = '0; rdy4 = 1'b0;
    req3 = '0; rdy3 = 1'b0;
    model_clear();
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    #2;
    total_cnt++;
    if ({v4, s4, g4, a4} !== 11'b0) $display("FAIL reset4 got=%h exp=0", {v4, s4, g4, a4});
    else pass_cnt++;
    total_cnt++;
    if ({v3, s3, g3, a3} !== 9'b0) $display("FAIL reset3 got=%h exp=0", {v3, s3, g3, a3});
    else pass_cnt++;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req4 = 4'b0100;
    tick();
    total_cnt++;
    if ({v4, s4, g4} !== {1'b1, 2'd2, 4'b0100}) $display("FAIL t1_grant got=%h exp=%h", {v4, s4, g4}, {1'b1, 2'd2, 4'b0100});
    else pass_cnt++;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    model_clear();
    #1;
    total_cnt++;
    if ({v4, s4, g4, a4} !== 11'b0) $display("FAIL t1_async got=%h exp=0", {v4, s4, g4, a4});
    else pass_cnt++;
    @(posedge clk);
    #2 reset = 1'b0;
    req4 = 4'b0001;
    tick();
    total_cnt++;
    if ({v4, s4, g4} !== {1'b1, 2'd0, 4'b0001}) $display("FAIL t1_after got=%h exp=%h", {v4, s4, g4}, {1'b1, 2'd0, 4'b0001});
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    do_reset();
    req4 = 4'b1111;
    rdy4 = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      total_cnt++;
      if ({v4, s4, a4} !== {1'b1, 2'(k % 4), 4'(1 << (k % 4))})
        $display("FAIL t2_rr%0d got=%h exp=%h", k, {v4, s4, a4}, {1'b1, 2'(k % 4), 4'(1 << (k % 4))});
      else pass_cnt++;
      tick();
    end
    req4 = '0;
    tick();
    total_cnt++;
    if ({v4, g4} !== 5'b0) $display("FAIL t2_drain got=%h exp=0", {v4, g4});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    req4 = 4'b0101;
    tick();
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if ({v4, s4, a4} !== {1'b1, 2'd0, 4'b0000}) $display("FAIL t3_hold%0d got=%h exp=%h", k, {v4, s4, a4}, {1'b1, 2'd0, 4'b0000});
      else pass_cnt++;
      tick();
    end
    rdy4 = 1'b1;
    #1;
    total_cnt++;
    if (a4 !== 4'b0001) $display("FAIL t3_ack got=%b exp=0001", a4);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({v4, s4} !== {1'b1, 2'd2}) $display("FAIL t3_next got=%h exp=%h", {v4, s4}, {1'b1, 2'd2});
    else pass_cnt++;
    req4 = 4'b0100;
    tick();
    req4 = '0;
    tick();
  endtask

  task automatic test_wrap_non_pow2();
    do_reset();
    req3 = 3'b010;
    rdy3 = 1'b1;
    tick();
    total_cnt++;
    if ({v3, s3} !== {1'b1, 2'd1}) $display("FAIL t4_first got=%h exp=%h", {v3, s3}, {1'b1, 2'd1});
    else pass_cnt++;
    req3 = '0;
    tick();
    req3 = 3'b100;
    tick();
    total_cnt++;
    if ({v3, s3, g3} !== {1'b1, 2'd2, 3'b100}) $display("FAIL t4_top got=%h exp=%h", {v3, s3, g3}, {1'b1, 2'd2, 3'b100});
    else pass_cnt++;
    req3 = 3'b011;
    tick();
    total_cnt++;
    if ({v3, s3, g3} !== {1'b1, 2'd0, 3'b001}) $display("FAIL t4_wrap got=%h exp=%h", {v3, s3, g3}, {1'b1, 2'd0, 3'b001});
    else pass_cnt++;
    req3 = 3'b010;
    tick();
    total_cnt++;
    if ({v3, s3, g3, a3} !== exp3()) $display("FAIL t4_model got=%h exp=%h", {v3, s3, g3, a3}, exp3());
    else pass_cnt++;
    req3 = '0;
    tick();
  endtask

  task automatic test_withdrawn_req();
    do_reset();
    req4 = 4'b0010;
    tick();
    req4 = '0;
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if ({v4, s4, a4} !== {1'b1, 2'd1, 4'b0000}) $display("FAIL t5_hold%0d got=%h exp=%h", k, {v4, s4, a4}, {1'b1, 2'd1, 4'b0000});
      else pass_cnt++;
      tick();
    end
    rdy4 = 1'b1;
    #1;
    total_cnt++;
    if (a4 !== 4'b0010) $display("FAIL t5_ack got=%b exp=0010", a4);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({v4, g4, a4} !== 9'b0) $display("FAIL t5_idle got=%h exp=0", {v4, g4, a4});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_single();
    do_reset();
    req4 = 4'b0001;
    rdy4 = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      total_cnt++;
      if ({v4, s4, a4} !== {(k % 2) == 0, 2'd0, ((k % 2) == 0) ? 4'b0001 : 4'b0000})
        $display("FAIL t6_alt%0d got=%h exp=%h", k, {v4, s4, a4}, {(k % 2) == 0, 2'd0, ((k % 2) == 0) ? 4'b0001 : 4'b0000});
      else pass_cnt++;
      tick();
    end
    req4 = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req4 = 4'($urandom);
      rdy4 = ($urandom % 4) != 0;
      req3 = 3'($urandom);
      rdy3 = ($urandom % 3) != 0;
      #1;
      total_cnt++;
      if ({v4, s4, g4, a4} !== exp4()) $display("FAIL rnd4_%0d got=%h exp=%h", k, {v4, s4, g4, a4}, exp4());
      else pass_cnt++;
      total_cnt++;
      if ({v3, s3, g3, a3} !== exp3() || s3 > 2'd2) $display("FAIL rnd3_%0d got=%h exp=%h", k, {v3, s3, g3, a3}, exp3());
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_busy();
    test_fairness();
    test_backpressure();
    test_wrap_non_pow2();
    test_withdrawn_req();
    test_back_to_back_single();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
